// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte/half/word accesses over a req/ack data-memory
// handshake, load-data extension, pipeline stall while an access is in flight,
// and abort with a fault pulse when memory never answers.
//
// state  | meaning
// IDLE   | waiting for a request; legal requests stall combinationally
// ACCESS | strobe held on the memory bus, counting cycles toward timeout
// DONE   | one non-stalled cycle so the pipeline advances; requests ignored
module load_store_unit #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 8
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] address_i,
   input  logic [31:0] store_data_i,
   output logic [31:0] load_data_o,
   output logic        busy_wait_o,
   output logic        fault_o,
   output logic        dmem_read_o,
   output logic        dmem_write_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_byte_en_o,
   input  logic [31:0] dmem_rdata_i,
   input  logic        dmem_ack_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               is_load_q, is_load_d;
   logic [2:0]         f3_q, f3_d;
   logic [1:0]         off_q, off_d;
   logic               dmem_read_q, dmem_read_d;
   logic               dmem_write_q, dmem_write_d;
   logic [31:0]        dmem_addr_q, dmem_addr_d;
   logic [31:0]        dmem_wdata_q, dmem_wdata_d;
   logic [3:0]         dmem_be_q, dmem_be_d;
   logic [31:0]        load_data_q, load_data_d;
   logic               fault_q, fault_d;
   logic               busy;

   logic               req, f3_ok, align_ok, legal, timeout;
   logic [3:0]         lane_be;
   logic [31:0]        lane_wdata;
   logic [31:0]        rdata_shift;
   logic [31:0]        load_ext;

   // Request legality: one direction, a funct3 valid for it, natural alignment.
   always_comb begin
      req      = mem_read_i | mem_write_i;
      f3_ok    = 1'b0;
      align_ok = 1'b0;
      case (funct3_i)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = ~mem_write_i;
         default:                f3_ok = 1'b0;
      endcase
      case (funct3_i[1:0])
         2'b00:   align_ok = 1'b1;
         2'b01:   align_ok = ~address_i[0];
         default: align_ok = (address_i[1:0] == 2'b00);
      endcase
      legal = (mem_read_i ^ mem_write_i) & f3_ok & align_ok;
   end

   // Store lane steering; loads always fetch the whole word.
   always_comb begin
      lane_be    = 4'b1111;
      lane_wdata = store_data_i;
      if (mem_write_i) begin
         case (funct3_i[1:0])
            2'b00: begin
               lane_be    = 4'b0001 << address_i[1:0];
               lane_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
               lane_be    = address_i[1] ? 4'b1100 : 4'b0011;
               lane_wdata = {2{store_data_i[15:0]}};
            end
            default: begin
               lane_be    = 4'b1111;
               lane_wdata = store_data_i;
            end
         endcase
      end else begin
         lane_wdata = '0;
      end
   end

   assign rdata_shift = dmem_rdata_i >> {off_q, 3'b000};

   // Select the addressed byte/half from the returned word and extend it.
   always_comb begin
      case (f3_q)
         3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
         3'b100:  load_ext = {24'h0, rdata_shift[7:0]};
         3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
         3'b101:  load_ext = {16'h0, rdata_shift[15:0]};
         default: load_ext = dmem_rdata_i;
      endcase
   end

   assign timeout = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   // Next-state, stall and datapath updates; ack takes priority over timeout.
   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      is_load_d    = is_load_q;
      f3_d         = f3_q;
      off_d        = off_q;
      dmem_read_d  = dmem_read_q;
      dmem_write_d = dmem_write_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      dmem_be_d    = dmem_be_q;
      load_data_d  = load_data_q;
      fault_d      = 1'b0;
      busy         = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (legal) begin
                  busy         = 1'b1;
                  state_d      = ACCESS;
                  is_load_d    = mem_read_i;
                  f3_d         = funct3_i;
                  off_d        = address_i[1:0];
                  dmem_addr_d  = {address_i[31:2], 2'b00};
                  dmem_wdata_d = lane_wdata;
                  dmem_be_d    = lane_be;
                  dmem_read_d  = mem_read_i;
                  dmem_write_d = mem_write_i;
               end else begin
                  fault_d = 1'b1;
               end
            end
         end
         ACCESS: begin
            busy  = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (dmem_ack_i) begin
               dmem_read_d  = 1'b0;
               dmem_write_d = 1'b0;
               if (is_load_q) load_data_d = load_ext;
               state_d = DONE;
            end else if (timeout) begin
               dmem_read_d  = 1'b0;
               dmem_write_d = 1'b0;
               fault_d      = 1'b1;
               if (is_load_q) load_data_d = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; reset abandons any access in flight.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         is_load_q    <= 1'b0;
         f3_q         <= 3'b000;
         off_q        <= 2'b00;
         dmem_read_q  <= 1'b0;
         dmem_write_q <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_wdata_q <= '0;
         dmem_be_q    <= '0;
         load_data_q  <= '0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         is_load_q    <= is_load_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         dmem_read_q  <= dmem_read_d;
         dmem_write_q <= dmem_write_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         dmem_be_q    <= dmem_be_d;
         load_data_q  <= load_data_d;
         fault_q      <= fault_d;
      end
   end

   assign load_data_o    = load_data_q;
   assign busy_wait_o    = busy;
   assign fault_o        = fault_q;
   assign dmem_read_o    = dmem_read_q;
   assign dmem_write_o   = dmem_write_q;
   assign dmem_addr_o    = dmem_addr_q;
   assign dmem_wdata_o   = dmem_wdata_q;
   assign dmem_byte_en_o = dmem_be_q;

endmodule
